// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, query, broadcast and retire signals of the reorder buffer
interface reorder_buffer_if #(
    parameter int ROB_WIDTH_BIT = 3
);
    logic                     issue_valid;
    logic                     issue_has_rd;
    logic [4:0]               issue_rd;
    logic                     issue_done;
    logic [31:0]              issue_value;
    logic [ROB_WIDTH_BIT-1:0] issue_rob_id;
    logic                     full;
    logic                     empty;

    logic [ROB_WIDTH_BIT-1:0] q1_id;
    logic [ROB_WIDTH_BIT-1:0] q2_id;
    logic                     q1_ready;
    logic                     q2_ready;
    logic [31:0]              q1_value;
    logic [31:0]              q2_value;

    logic                     rs_ready;
    logic [ROB_WIDTH_BIT-1:0] rs_rob_id;
    logic [31:0]              rs_value;
    logic                     lsb_ready;
    logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
    logic [31:0]              lsb_value;

    logic                     commit_valid;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
    logic                     commit_has_rd;
    logic [4:0]               commit_rd;
    logic [31:0]              commit_value;

    modport master (
        output issue_valid, issue_has_rd, issue_rd, issue_done, issue_value,
        output q1_id, q2_id,
        output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        input  issue_rob_id, full, empty,
        input  q1_ready, q2_ready, q1_value, q2_value,
        input  commit_valid, commit_rob_id, commit_has_rd, commit_rd, commit_value
    );

    modport slave (
        input  issue_valid, issue_has_rd, issue_rd, issue_done, issue_value,
        input  q1_id, q2_id,
        input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        output issue_rob_id, full, empty,
        output q1_ready, q2_ready, q1_value, q2_value,
        output commit_valid, commit_rob_id, commit_has_rd, commit_rd, commit_value
    );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with result capture and operand lookup
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush,
    reorder_buffer_if.slave bus
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = (ROB_WIDTH_BIT+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0]      r_busy;
    logic [ROB_SIZE-1:0]      r_done;
    logic [ROB_SIZE-1:0]      r_has_rd;
    logic [4:0]               r_rd    [ROB_SIZE];
    logic [31:0]              r_value [ROB_SIZE];
    logic [ROB_WIDTH_BIT-1:0] r_head;
    logic [ROB_WIDTH_BIT-1:0] r_tail;
    logic [ROB_WIDTH_BIT:0]   r_count;

    logic                     r_commit_valid;
    logic [ROB_WIDTH_BIT-1:0] r_commit_rob_id;
    logic                     r_commit_has_rd;
    logic [4:0]               r_commit_rd;
    logic [31:0]              r_commit_value;

    logic                     w_full;
    logic                     w_issue_ok;
    logic                     w_commit;
    logic                     w_rs_hit;
    logic                     w_lsb_hit;
    logic [ROB_WIDTH_BIT:0]   w_count_next;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_issue_ok = bus.issue_valid && !w_full;
    assign w_commit   = r_busy[r_head] && r_done[r_head];
    assign w_rs_hit   = bus.rs_ready && r_busy[bus.rs_rob_id];
    assign w_lsb_hit  = bus.lsb_ready && r_busy[bus.lsb_rob_id];

    always_comb begin
        w_count_next = r_count;
        if (w_issue_ok && !w_commit)
            w_count_next = r_count + 1'b1;
        else if (!w_issue_ok && w_commit)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy          <= '0;
            r_done          <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_valid  <= 1'b0;
            r_commit_rob_id <= '0;
            r_commit_has_rd <= 1'b0;
            r_commit_rd     <= '0;
            r_commit_value  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_busy         <= '0;
                r_done         <= '0;
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
                r_commit_valid <= 1'b0;
            end else begin
                r_commit_valid <= w_commit;
                if (w_commit) begin
                    r_commit_rob_id <= r_head;
                    r_commit_has_rd <= r_has_rd[r_head];
                    r_commit_rd     <= r_rd[r_head];
                    r_commit_value  <= r_value[r_head];
                    r_busy[r_head]  <= 1'b0;
                    r_head          <= r_head + 1'b1;
                end
                if (w_issue_ok) begin
                    r_busy[r_tail] <= 1'b1;
                    r_done[r_tail] <= bus.issue_done;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_rs_hit)
                    r_done[bus.rs_rob_id] <= 1'b1;
                if (w_lsb_hit)
                    r_done[bus.lsb_rob_id] <= 1'b1;
                r_count <= w_count_next;
            end
        end
    end

    // Payload needs no reset: an entry is only read once busy, and issue always rewrites it.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            if (w_issue_ok) begin
                r_has_rd[r_tail] <= bus.issue_has_rd;
                r_rd[r_tail]     <= bus.issue_rd;
                r_value[r_tail]  <= bus.issue_value;
            end
            if (w_rs_hit)
                r_value[bus.rs_rob_id] <= bus.rs_value;
            if (w_lsb_hit)
                r_value[bus.lsb_rob_id] <= bus.lsb_value;
        end
    end

    function automatic logic [32:0] f_lookup(input logic [ROB_WIDTH_BIT-1:0] id);
        if (r_done[id])
            return {1'b1, r_value[id]};
        else if (bus.rs_ready && bus.rs_rob_id == id)
            return {1'b1, bus.rs_value};
        else if (bus.lsb_ready && bus.lsb_rob_id == id)
            return {1'b1, bus.lsb_value};
        else
            return 33'd0;
    endfunction

    assign {bus.q1_ready, bus.q1_value} = f_lookup(bus.q1_id);
    assign {bus.q2_ready, bus.q2_value} = f_lookup(bus.q2_id);

    assign bus.issue_rob_id  = r_tail;
    assign bus.full          = w_full;
    assign bus.empty         = (r_count == '0);
    assign bus.commit_valid  = r_commit_valid;
    assign bus.commit_rob_id = r_commit_rob_id;
    assign bus.commit_has_rd = r_commit_has_rd;
    assign bus.commit_rd     = r_commit_rd;
    assign bus.commit_value  = r_commit_value;
endmodule
